uart_frame_parser: RTL
======================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter SYNC_BYTE, 8'hA5, frame start marker.
REQ-002 Parameter MAX_LEN, 8, maximum payload bytes per frame (range 1..15).
REQ-003 Parameter TIMEOUT_CYCLES, 200_000, maximum clk_in cycles allowed between bytes inside a frame.
REQ-004 clk_in  input  1  system clock; the block has a single clock domain.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 byte_in  input  8  received byte from the upstream UART receiver, valid at the rising edge of byte_ready.
REQ-007 byte_ready  input  1  upstream idle level; low while a byte is being shifted in, high otherwise.
REQ-008 frame_ack  input  1  consumer accepts the held frame.
REQ-009 frame_data  output  8*MAX_LEN  payload; byte i is at bits [8i+7:8i]; unused bytes are zero.
REQ-010 frame_len  output  4  payload byte count of the held frame.
REQ-011 frame_valid  output  1  held frame present; level signal until acknowledged.
REQ-012 err_chk, err_len, err_timeout, err_overrun  output  1 each  single-cycle error pulses.

Function
REQ-013 The block shall register byte_ready as ready_last each cycle and define byte_stb = byte_ready && !ready_last; byte_in shall be sampled only in byte_stb cycles.
REQ-014 Frame format: SYNC_BYTE, LEN, LEN payload bytes, then CHK = XOR of LEN and all payload bytes.
REQ-015 The FSM shall have states HUNT, GET_LEN, GET_PAYLOAD and GET_CHK.
REQ-016 In HUNT: on byte_stb with byte_in==SYNC_BYTE, go to GET_LEN; any other byte is silently dropped.
REQ-017 In GET_LEN: on byte_stb, if byte_in is 0 or greater than MAX_LEN, pulse err_len and go to HUNT; otherwise store LEN, init the running XOR to byte_in, clear the payload index, clear the working buffer, and go to GET_PAYLOAD.
REQ-018 In GET_PAYLOAD: on each byte_stb, write byte_in to working-buffer slot index, XOR it into the running checksum, and increment the index; after the LEN-th byte, go to GET_CHK.
REQ-019 In GET_CHK: on byte_stb, if byte_in equals the running XOR, complete the frame (REQ-021) and go to HUNT; otherwise pulse err_chk and go to HUNT.
REQ-020 An idle counter shall clear on every byte_stb and increment every other cycle in GET_LEN, GET_PAYLOAD and GET_CHK; on reaching TIMEOUT_CYCLES it shall pulse err_timeout and force HUNT; it shall hold at 0 in HUNT.
REQ-021 Completion: on the clock edge ending the CHK byte_stb cycle, copy the working buffer to frame_data, copy LEN to frame_len, and set frame_valid, so outputs are visible one cycle after the strobe.
REQ-022 frame_ack while frame_valid is high shall clear frame_valid on the next edge; frame_ack while frame_valid is low shall be ignored.
REQ-023 frame_data and frame_len shall remain stable while frame_valid is high.
REQ-024 Completion while frame_valid is high and frame_ack is low: discard the new frame, keep the held frame unchanged, and pulse err_overrun.
REQ-025 Completion and frame_ack in the same cycle: load the new frame, keep frame_valid high, and do not pulse err_overrun.
REQ-026 Parsing shall continue in every state regardless of frame_valid.
REQ-027 Each err_* output shall be high for exactly one cycle per event and low otherwise.
REQ-028 The idle counter shall be 32 bits wide and the payload index shall be 4 bits wide.

Reset
REQ-029 While rst_in is high, set: state=HUNT; frame_valid=0; frame_data=0; frame_len=0; all err_* = 0; idle counter=0; index=0; running XOR=0; ready_last=1.
REQ-030 Reset in the middle of a frame shall discard the partial frame; the next frame shall be accepted only after a fresh SYNC_BYTE.
REQ-031 ready_last resetting to 1 shall prevent a spurious byte_stb on the first cycle after reset.

Verification
REQ-032 Bytes A5,03,11,22,33,03 -> frame_valid=1 one cycle after the last strobe, frame_len=3, frame_data low 24 bits = 0x332211, remaining bits 0; no error pulse.
REQ-033 Bytes A5,02,10,20,00 -> err_chk pulses once, frame_valid stays 0; a following valid frame is then accepted.
REQ-034 Bytes A5,09 (MAX_LEN=8) -> err_len pulse; bytes A5,00 -> err_len pulse; FSM returns to HUNT.
REQ-035 Bytes A5,02,10 then no strobe for TIMEOUT_CYCLES -> exactly one err_timeout pulse and return to HUNT; the next A5,01,7F,7E frame completes.
REQ-036 Two valid frames with no ack -> first frame held, err_overrun pulses; repeat with frame_ack in the completion cycle -> second frame loaded, frame_valid stays 1, no overrun.
REQ-037 rst_in for one cycle after A5,03,11 -> all outputs 0; bytes 22,33,03 alone produce no frame and no error.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts for SYNC_BYTE, collects a length-prefixed payload,
// verifies the XOR checksum and presents the frame until it is acknowledged.
// Malformed, stalled and overrunning frames raise one-cycle error pulses.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 200_000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [7:0]             byte_in,
  input  logic                   byte_ready,
  input  logic                   frame_ack,
  output logic [8*MAX_LEN-1:0]   frame_data,
  output logic [3:0]             frame_len,
  output logic                   frame_valid,
  output logic                   err_chk,
  output logic                   err_len,
  output logic                   err_timeout,
  output logic                   err_overrun
);

  typedef enum logic [1:0] {HUNT, GET_LEN, GET_PAYLOAD, GET_CHK} state_t;

  state_t                   r_state, w_next;
  logic                     r_ready_last;
  logic [31:0]              r_idle;
  logic [3:0]               r_idx, r_len;
  logic [7:0]               r_xor;
  logic [MAX_LEN-1:0][7:0]  r_buf, r_frame;
  logic [3:0]               r_frame_len;
  logic                     r_valid;
  logic                     r_err_chk, r_err_len, r_err_timeout, r_err_overrun;

  logic w_stb, w_len_bad, w_chk_bad, w_complete, w_timeout, w_overrun, w_load;

  // A byte lands on the rising edge of byte_ready; ready_last resets high so
  // leaving reset with byte_ready high is not mistaken for a strobe.
  assign w_stb = byte_ready && !r_ready_last;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= HUNT;
    else        r_state <= w_next;
  end

  // Next-state logic and single-cycle event decode.
  always_comb begin
    w_next     = r_state;
    w_len_bad  = 1'b0;
    w_chk_bad  = 1'b0;
    w_complete = 1'b0;
    // The cycle that would bring the idle count to TIMEOUT_CYCLES ends the frame.
    w_timeout  = (r_state != HUNT) && !w_stb &&
                 (r_idle == 32'(TIMEOUT_CYCLES - 1));
    if (w_timeout) begin
      w_next = HUNT;
    end else begin
      case (r_state)
        HUNT: if (w_stb && byte_in == SYNC_BYTE) w_next = GET_LEN;
        GET_LEN: if (w_stb) begin
          if (byte_in == 8'd0 || byte_in > 8'(MAX_LEN)) begin
            w_len_bad = 1'b1;
            w_next    = HUNT;
          end else begin
            w_next    = GET_PAYLOAD;
          end
        end
        GET_PAYLOAD: if (w_stb && (r_idx + 4'd1 == r_len)) w_next = GET_CHK;
        GET_CHK: if (w_stb) begin
          if (byte_in == r_xor) w_complete = 1'b1;
          else                  w_chk_bad  = 1'b1;
          w_next = HUNT;
        end
        default: w_next = HUNT;
      endcase
    end
  end

  // A finished frame is dropped only if the held one is still unacknowledged.
  assign w_overrun = w_complete && r_valid && !frame_ack;
  assign w_load    = w_complete && !w_overrun;

  // Parser datapath: strobe edge detect, idle counter, length/index/checksum, working buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ready_last <= 1'b1;
      r_idle       <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_xor        <= '0;
      r_buf        <= '0;
    end else begin
      r_ready_last <= byte_ready;
      if (r_state == HUNT || w_stb || w_timeout) r_idle <= '0;
      else                                       r_idle <= r_idle + 32'd1;
      if (w_stb && r_state == GET_LEN && !w_len_bad) begin
        r_len <= byte_in[3:0];
        r_xor <= byte_in;
        r_idx <= '0;
        r_buf <= '0;
      end
      if (w_stb && r_state == GET_PAYLOAD) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (r_idx == 4'(i)) r_buf[i] <= byte_in;
        r_xor <= r_xor ^ byte_in;
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  // Held-frame register and error pulse outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_frame       <= '0;
      r_frame_len   <= '0;
      r_valid       <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_chk     <= w_chk_bad;
      r_err_len     <= w_len_bad;
      r_err_timeout <= w_timeout;
      r_err_overrun <= w_overrun;
      if (w_load) begin
        r_frame     <= r_buf;
        r_frame_len <= r_len;
        r_valid     <= 1'b1;
      end else if (frame_ack && r_valid) begin
        r_valid     <= 1'b0;
      end
    end
  end

  assign frame_data  = r_frame;
  assign frame_len   = r_frame_len;
  assign frame_valid = r_valid;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

endmodule
